// File: rtl/net_pkg.sv
// Shared definitions for the net_tx / net_rx serial link: FSM states,
// command pairs and the default sync word.
package net_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_CMD  = 3'd2,
    ST_DATA = 3'd3,
    ST_GAP  = 3'd4
  } net_state_e;

  // Command pairs; bit [1] goes on the wire first.
  localparam logic [1:0]  CMD_MORE = 2'b01;
  localparam logic [1:0]  CMD_END  = 2'b10;
  localparam logic [63:0] NET_SYNC = 64'h307A_1AFD_8FE3_A9DA;

  function automatic logic cmd_bit(input logic is_end, input logic second);
    logic [1:0] cmd;
    cmd = is_end ? CMD_END : CMD_MORE;
    return second ? cmd[0] : cmd[1];
  endfunction

endpackage

// File: rtl/net_tx_if.sv
// Word-level valid/ready handshake into net_tx.
interface net_tx_if #(
  parameter int BITS = 64
) ();
  logic [BITS-1:0] in_data;
  logic            in_end;
  logic            in_valid;
  logic            in_ready;

  modport master (output in_data, output in_end, output in_valid, input in_ready);
  modport slave  (input in_data, input in_end, input in_valid, output in_ready);
endinterface

// File: rtl/net_tx_lane_ser.sv
// One lane's LB-bit shift register. bit_o is the bit to send next: the LSB of
// the word being loaded, otherwise the LSB of the stored remainder.
module net_tx_lane_ser #(
  parameter int LB = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          shift,
  input  logic [LB-1:0] load_data,
  output logic          bit_o
);

  logic [LB-1:0] sreg_q;
  logic [LB-1:0] sreg_d;

  // The loaded word's bit 0 leaves immediately, so only the rest is stored.
  always_comb begin
    sreg_d = sreg_q;
    if (load) begin
      sreg_d = load_data >> 1'b1;
    end else if (shift) begin
      sreg_d = sreg_q >> 1'b1;
    end else begin
      sreg_d = sreg_q;
    end
  end

  assign bit_o = load ? load_data[0] : sreg_q[0];

  // Shift register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q <= '0;
    end else begin
      sreg_q <= sreg_d;
    end
  end

endmodule

// File: rtl/net_tx.sv
// Serial frame transmitter: SYNC, then (CMD, DATA) per word, then a 2-cycle GAP.
// Optional per-lane output polarity inversion with macro NET_TX_INVERT_EN.
module net_tx
  import net_pkg::*;
#(
  parameter int              BITS  = 64,
  parameter int              LANES = 1,
  parameter logic [BITS-1:0] SYNC  = BITS'(NET_SYNC)
) (
  input  logic             clk,
  input  logic             rst_n,
  net_tx_if.slave          tx,
  output logic [LANES-1:0] out_data,
  output logic             out_busy,
  output logic             err_underflow
`ifdef NET_TX_INVERT_EN
  ,
  input  logic [LANES-1:0] in_invert
`endif
);

  localparam int LB = BITS / LANES;
  localparam int CW = $clog2(LB + 1);
  localparam int IW = (LB > 1) ? $clog2(LB) : 1;
  localparam logic [CW-1:0] LAST = CW'(LB - 1);

  net_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BITS-1:0]  hold_data_q, hold_data_d;
  logic             hold_end_q, hold_end_d;
  logic             hold_valid_q, hold_valid_d;
  logic             cur_end_q, cur_end_d;
  logic [LANES-1:0] out_data_q, out_data_d;
  logic             out_busy_q, out_busy_d;
  logic             err_q, err_d;

  logic             xfer_s, load_s, shift_s, cmd_bit_s;
  logic [IW-1:0]    cnt_idx_s;
  logic [LANES-1:0] out_raw_s;

  assign tx.in_ready = !hold_valid_q;
  assign xfer_s      = tx.in_valid && !hold_valid_q;

  // Next state, counter and hold register; a word may arrive on the last DATA edge.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CW'(1);
    hold_data_d  = hold_data_q;
    hold_end_d   = hold_end_q;
    hold_valid_d = hold_valid_q;
    cur_end_d    = cur_end_q;
    load_s       = 1'b0;
    shift_s      = 1'b0;
    err_d        = 1'b0;
    if (xfer_s) begin
      hold_data_d  = tx.in_data;
      hold_end_d   = tx.in_end;
      hold_valid_d = 1'b1;
    end else begin
      hold_valid_d = hold_valid_q;
    end
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (hold_valid_q) state_d = ST_SYNC;
        else              state_d = ST_IDLE;
      end
      ST_SYNC: begin
        if (cnt_q == LAST) begin
          state_d = ST_CMD;
          cnt_d   = '0;
        end else begin
          state_d = ST_SYNC;
        end
      end
      ST_CMD: begin
        if (cnt_q == CW'(1)) begin
          state_d      = ST_DATA;
          cnt_d        = '0;
          load_s       = 1'b1;
          cur_end_d    = hold_end_q;
          hold_valid_d = 1'b0;
        end else begin
          state_d = ST_CMD;
        end
      end
      ST_DATA: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (cur_end_q) begin
            state_d = ST_GAP;
          end else if (hold_valid_q || xfer_s) begin
            state_d = ST_CMD;
          end else begin
            state_d = ST_GAP;
            err_d   = 1'b1;
          end
        end else begin
          state_d = ST_DATA;
          shift_s = 1'b1;
        end
      end
      ST_GAP: begin
        if (cnt_q == CW'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          state_d = ST_GAP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output bits are chosen from the state being entered so they line up with state_q.
  assign cnt_idx_s = IW'(cnt_d);
  assign cmd_bit_s = cmd_bit(hold_end_d, cnt_d[0]);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [LB-1:0] sync_lane_s;
    logic          ser_bit_s;
    logic          lane_bit_s;

    assign sync_lane_s = SYNC[g*LB +: LB];

    net_tx_lane_ser #(.LB(LB)) u_ser (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load_s),
      .shift     (shift_s),
      .load_data (hold_data_q[g*LB +: LB]),
      .bit_o     (ser_bit_s)
    );

    // Per-lane bit mux.
    always_comb begin
      lane_bit_s = 1'b0;
      case (state_d)
        ST_SYNC: lane_bit_s = sync_lane_s[cnt_idx_s];
        ST_CMD:  lane_bit_s = cmd_bit_s;
        ST_DATA: lane_bit_s = ser_bit_s;
        default: lane_bit_s = 1'b0;
      endcase
    end

    assign out_raw_s[g] = lane_bit_s;
  end

  // Polarity applies in every state, idle and gap included.
  always_comb begin
`ifdef NET_TX_INVERT_EN
    out_data_d = out_raw_s ^ in_invert;
`else
    out_data_d = out_raw_s;
`endif
    out_busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      hold_data_q  <= '0;
      hold_end_q   <= 1'b0;
      hold_valid_q <= 1'b0;
      cur_end_q    <= 1'b0;
      out_data_q   <= '0;
      out_busy_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hold_data_q  <= hold_data_d;
      hold_end_q   <= hold_end_d;
      hold_valid_q <= hold_valid_d;
      cur_end_q    <= cur_end_d;
      out_data_q   <= out_data_d;
      out_busy_q   <= out_busy_d;
      err_q        <= err_d;
    end
  end

  assign out_data      = out_data_q;
  assign out_busy      = out_busy_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_net_tx.sv
// Scoreboard bench for net_tx: one 1-lane and one 4-lane instance share the
// stimulus; the expected per-cycle wire stream is queued when a frame is offered.
`timescale 1ns/1ps
module tb_net_tx;

  localparam logic [63:0] SYNC_W = 64'h307A_1AFD_8FE3_A9DA;

  typedef struct packed {
    logic [3:0] out;
    logic       busy;
    logic       err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] drv_data = '0;
  logic        drv_end = 1'b0;
  logic        drv_valid = 1'b0;
  int          sel = 1;

  logic [0:0]  out1;
  logic [3:0]  out4;
  logic        busy1, busy4, err1, err4;
  logic [3:0]  mon_out;
  logic        mon_busy, mon_err, ready_s;

  exp_t        exp_q[$];
  logic [63:0] wl[4];
  logic        el[4];
  int          n_tests = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  net_tx_if #(.BITS(64)) if1 ();
  net_tx_if #(.BITS(64)) if4 ();

  assign if1.in_data  = drv_data;
  assign if1.in_end   = drv_end;
  assign if1.in_valid = drv_valid && (sel == 1);
  assign if4.in_data  = drv_data;
  assign if4.in_end   = drv_end;
  assign if4.in_valid = drv_valid && (sel == 4);

  net_tx #(.BITS(64), .LANES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .tx(if1), .out_data(out1),
    .out_busy(busy1), .err_underflow(err1)
`ifdef NET_TX_INVERT_EN
    , .in_invert(1'b0)
`endif
  );

  net_tx #(.BITS(64), .LANES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .tx(if4), .out_data(out4),
    .out_busy(busy4), .err_underflow(err4)
`ifdef NET_TX_INVERT_EN
    , .in_invert(4'b0000)
`endif
  );

  assign mon_out  = (sel == 1) ? {3'b000, out1} : out4;
  assign mon_busy = (sel == 1) ? busy1 : busy4;
  assign mon_err  = (sel == 1) ? err1 : err4;
  assign ready_s  = (sel == 1) ? if1.in_ready : if4.in_ready;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic [3:0] o, input logic b, input logic er);
    exp_t e;
    e.out  = o;
    e.busy = b;
    e.err  = er;
    exp_q.push_back(e);
  endtask

  // Expected wire stream, one entry per cycle, starting the cycle after acceptance.
  task automatic push_frame(input int lanes, input int n);
    int          lb;
    logic [3:0]  v, mask;
    logic [63:0] s, w;
    lb   = 64 / lanes;
    mask = (lanes == 1) ? 4'b0001 : 4'b1111;
    s    = SYNC_W;
    push(4'b0000, 1'b0, 1'b0);
    for (int k = 0; k < lb; k++) begin
      v = '0;
      for (int l = 0; l < lanes; l++) v[l] = s[l*lb + k];
      push(v, 1'b1, 1'b0);
    end
    for (int i = 0; i < n; i++) begin
      push(el[i] ? mask : 4'b0000, 1'b1, 1'b0);
      push(el[i] ? 4'b0000 : mask, 1'b1, 1'b0);
      w = wl[i];
      for (int k = 0; k < lb; k++) begin
        v = '0;
        for (int l = 0; l < lanes; l++) v[l] = w[l*lb + k];
        push(v, 1'b1, 1'b0);
      end
    end
    push(4'b0000, 1'b1, !el[n-1]);
    push(4'b0000, 1'b1, 1'b0);
    push(4'b0000, 1'b0, 1'b0);
  endtask

  // Offers wl/el[0..n-1]; the last word is delayed dly cycles inside its window.
  task automatic send_frame(input int lanes, input int n, input int dly);
    int t;
    @(negedge clk); #1;
    sel = lanes;
    check("ready_idle", 64'(ready_s), 64'd1);
    push_frame(lanes, n);
    drv_data  = wl[0];
    drv_end   = el[0];
    drv_valid = 1'b1;
    for (int i = 1; i < n; i++) begin
      @(negedge clk); #1;
      drv_valid = 1'b0;
      check("hold_full", 64'(ready_s), 64'd0);
      t = 0;
      while (!ready_s && t < 300) begin
        @(negedge clk); #1;
        t++;
      end
      check("ready_wait", 64'(ready_s), 64'd1);
      if (i == n - 1) begin
        repeat (dly) begin
          @(negedge clk); #1;
        end
      end
      drv_data  = wl[i];
      drv_end   = el[i];
      drv_valid = 1'b1;
    end
    @(negedge clk); #1;
    drv_valid = 1'b0;
    t = 0;
    while (exp_q.size() > 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
  endtask

  // Scoreboard: pop one expected cycle per falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("out_data", 64'(mon_out), 64'(e.out));
      check("out_busy", 64'(mon_busy), 64'(e.busy));
      check("err_underflow", 64'(mon_err), 64'(e.err));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset, with a word offered that must be ignored.
    drv_valid = 1'b1;
    drv_data  = 64'hDEAD_BEEF_0000_0001;
    drv_end   = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_out1", 64'(out1), 64'd0);
    check("rst_busy1", 64'(busy1), 64'd0);
    check("rst_err1", 64'(err1), 64'd0);
    check("rst_out4", 64'(out4), 64'd0);
    check("rst_busy4", 64'(busy4), 64'd0);
    check("rst_ready1", 64'(if1.in_ready), 64'd1);
    #1;
    rst_n     = 1'b1;
    drv_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_busy1", 64'(busy1), 64'd0);
    check("post_rst_ready1", 64'(if1.in_ready), 64'd1);

    // Single word, one lane.
    wl[0] = 64'h0123_4567_89AB_CDEF; el[0] = 1'b1;
    send_frame(1, 1, 0);

    // Three words back-to-back.
    wl[0] = 64'hA5A5_0F0F_1234_5678; el[0] = 1'b0;
    wl[1] = 64'h8000_0000_0000_0001; el[1] = 1'b0;
    wl[2] = 64'hFEDC_BA98_7654_3210; el[2] = 1'b1;
    send_frame(1, 3, 0);

    // Second word accepted on the last DATA edge.
    wl[0] = 64'h1111_2222_3333_4444; el[0] = 1'b0;
    wl[1] = 64'hCAFE_F00D_0BAD_BEEF; el[1] = 1'b1;
    send_frame(1, 2, 63);

    // Four lanes.
    wl[0] = 64'hFFFF_0000_AAAA_5555; el[0] = 1'b1;
    send_frame(4, 1, 0);
    wl[0] = 64'h0F1E_2D3C_4B5A_6978; el[0] = 1'b0;
    wl[1] = 64'h9876_5432_10FE_DCBA; el[1] = 1'b1;
    send_frame(4, 2, 15);

    // Underflow, then the late word starts a fresh frame.
    wl[0] = 64'h5A5A_5A5A_C3C3_C3C3; el[0] = 1'b0;
    send_frame(1, 1, 0);
    wl[0] = 64'h0000_0000_0000_00FF; el[0] = 1'b1;
    send_frame(1, 1, 0);

    // Reset in the middle of DATA (bit 10 of an all-ones word).
    sel = 1;
    @(negedge clk); #1;
    drv_data  = '1;
    drv_end   = 1'b1;
    drv_valid = 1'b1;
    @(negedge clk); #1;
    drv_valid = 1'b0;
    repeat (77) @(negedge clk);
    #2;
    check("pre_rst_busy", 64'(busy1), 64'd1);
    check("pre_rst_out", 64'(out1), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_out", 64'(out1), 64'd0);
    check("async_rst_busy", 64'(busy1), 64'd0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    check("rst_rel_ready", 64'(if1.in_ready), 64'd1);
    repeat (3) @(negedge clk);
    check("rst_rel_busy", 64'(busy1), 64'd0);
    wl[0] = 64'h7777_8888_9999_AAAA; el[0] = 1'b1;
    send_frame(1, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/net_tx.md
# net_tx

Serial frame transmitter, the sending end of the `net_rx` link. It accepts BITS-wide words over a valid/ready handshake and drives LANES single-bit lanes at one bit per lane per `clk` cycle. Each frame is a sync word, then one or more command-prefixed data words, then a gap. It sits in the sending device's clock domain, directly before the output pads.

## Interface
- `BITS`, 64: word width; must be divisible by LANES; LB = BITS/LANES is the number of bits per lane per word.
- `LANES`, 1: number of serial lanes.
- `SYNC`, 64'h307A1AFD8FE3A9DA: sync pattern; bits `[l*LB +: LB]` go on lane l.
- `clk`  in  1: bit clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `in_data`  in  BITS: word to send.
- `in_end`  in  1: this word is the last word of the frame.
- `in_valid`  in  1: a word is offered.
- `in_ready`  out  1: equals `!hold_valid`; a transfer happens when `in_valid && in_ready`.
- `out_data`  out  LANES: registered serial lane outputs.
- `out_busy`  out  1: registered; high whenever state != IDLE.
- `err_underflow`  out  1: registered one-cycle pulse when a frame is aborted.
- `in_invert`  in  LANES: per-lane polarity. Present only with `NET_TX_INVERT_EN`.

## Operation
- Lane mapping: lane l carries word bits `[l*LB +: LB]`, sent LSB first. All lanes move in lockstep.
- Hold register: stores one word plus its end flag. It loads on a transfer and clears when the word moves into the shift register.
- States and output per cycle:
  - IDLE: output 0.
  - SYNC: LB cycles of SYNC bits.
  - CMD: 2 cycles of command bits.
  - DATA: LB cycles of word bits.
  - GAP: 2 cycles of 0.
- Command bits, in transmit order:
  - More words follow: 0, 1.
  - Last word (end): 1, 0.
  - The GAP bits (0, 0) read as an invalid command, which forces the receiver back to idle.
- Transitions:
  - IDLE → SYNC when `hold_valid`.
  - SYNC → CMD after LB cycles. Command bits come from the hold end flag.
  - CMD → DATA after 2 cycles. The hold word loads into the shift register and `hold_valid` clears.
  - DATA → CMD on the last bit, if the current word is not end and `hold_valid` is set.
  - DATA → GAP on the last bit, if the current word is end.
  - DATA → GAP on the last bit with an `err_underflow` pulse, if the word is not end and the hold is empty. The frame is truncated without an end marker.
  - GAP → IDLE after 2 cycles. Frames therefore never abut.
- Words offered during GAP or IDLE wait in the hold register for the next frame.
- A single counter of width `$clog2(LB+1)` is shared by SYNC and DATA; it reloads on each state change.

## Timing
- Reset values: `out_data`=0, `out_busy`=0, `err_underflow`=0, state IDLE, `hold_valid`=0. `in_ready` is therefore 1; transfers during reset are ignored.
- Accept edge T with idle state: `hold_valid` is set after T. SYNC bit 0 appears after edge T+1.
- Frame layout from edge T+1:
  - SYNC occupies LB cycles.
  - CMD follows for 2 cycles.
  - DATA follows for LB cycles.
  - Total per frame: LB + N·(LB+2) + 2 cycles.
- Next-word window: after a word is consumed (CMD→DATA), `in_ready` is high for LB cycles. A word accepted on any of those edges, including the last DATA edge, continues the frame without a bubble.
- Reset mid-frame: `out_data` goes to 0 asynchronously and the hold word is discarded. The receiver sees a truncated frame.
- Simultaneous transfer and consume: cannot happen, because `in_ready` is low whenever the hold is full.

## Configuration
- `NET_TX_INVERT_EN` defined: the `in_invert` port exists. `out_data[l]` is XORed with `in_invert[l]` before the output register, covering all states including IDLE and GAP. The value is sampled every cycle.
- `NET_TX_INVERT_EN` undefined: no `in_invert` port; outputs are uninverted.

## Structure
- Shared package `net_pkg`:
  - state enum (IDLE/SYNC/CMD/DATA/GAP);
  - command constants CMD_MORE = {0,1} and CMD_END = {1,0} in transmit order;
  - default SYNC constant, also used by `net_rx`.
- Sub-module `net_tx_lane_ser`: one per lane. It contains an LB-bit shift register with parallel load and a right shift that emits the LSB.

## Test plan
- BITS=64, LANES=1: one word `64'h0123456789ABCDEF` with end=1 → 64 SYNC bits (LSB 0, then 1, 0, 1, 1…), then 1, 0, then the data LSB first (1, 1, 1, 1, 0, 1, 1, 1…), then 0, 0. Busy for 132 cycles.
- Three words, end on the third, each offered back-to-back on the first `in_ready` → commands 01, 01, 10. No bubbles; frame is 64+3·66+2 = 264 cycles.
- LANES=4, word `64'hFFFF_0000_AAAA_5555` → lane 0 sends 1, 0, 1, 0…; lane 1 sends 0, 1, 0, 1…; lane 2 sends 0s; lane 3 sends 1s. The SYNC nibble split per lane is checked.
- Second word withheld → `err_underflow` pulses on the last DATA edge, then 2 gap cycles. `out_busy` falls; the late word starts a new frame with SYNC.
- `rst_n` asserted mid-DATA → `out_data`=0 and `out_busy`=0 immediately. After release, `in_ready`=1 and the next word starts a clean frame. Loopback into `net_rx` yields no `out_valid` for the aborted word.
- With `NET_TX_INVERT_EN` and `in_invert`=1 → every bit is complemented. In loopback, `net_rx` reports polarity 1 and the data is recovered correctly.
